input_feeder: RTL and testbench
===============================

// Module: input_feeder
// PURPOSE
//  Upstream stage of input_skewer. Accepts one MATRIX_SIZE x MATRIX_SIZE operand matrix
//  row-by-row over a valid/ready handshake and buffers it. It then streams the matrix
//  column-by-column as an unskewed vector with an enable strobe. Finally it drains zeros so
//  the skewer and systolic array flush. One matrix per transaction; no overlap of load/stream.
// PARAMETERS
//  MATRIX_SIZE   2               rows/cols of operand matrix; >=1
//  DATA_SIZE     32              bits per element
//  DRAIN_CYCLES  3*MATRIX_SIZE   zero-vector cycles after last column; >=0
// PORTS
//  clk          in   1                      clock, all state on rising edge
//  reset        in   1                      asynchronous, active-high
//  flush        in   1                      sync abort: drop current transaction, back to LOAD
//  in_valid     in   1                      row_in holds a valid matrix row
//  in_ready     out  1                      feeder accepts row_in this cycle
//  row_in       in   DATA_SIZE x MATRIX_SIZE unpacked [MATRIX_SIZE-1:0]; row_in[k]=A[r][k]
//  stall        in   1                      downstream hold; freezes STREAM/DRAIN progress
//  data_out     out  DATA_SIZE x MATRIX_SIZE unpacked; data_out[i]=A[i][col] in STREAM
//  enable_out   out  1                      drives input_skewer enable_in; vector is consumed
//  busy         out  1                      high in STREAM or DRAIN
//  done         out  1                      1-cycle pulse after last drain cycle
// BEHAVIOUR
//  Reset (async): state=LOAD, row_cnt=0, col_cnt=0, drain_cnt=0.
//   Outputs: in_ready=1, enable_out=0, busy=0, done=0, data_out=all 0. Buffer contents are
//   don't-care. Reset mid-transaction discards everything.
//  States: LOAD -> STREAM -> DRAIN -> DONE -> LOAD.
//  LOAD: in_ready=!flush. A row is accepted on a cycle with in_valid&&in_ready.
//   It is stored to buf[row_cnt]. row_cnt increments.
//   On acceptance of row MATRIX_SIZE-1: row_cnt<=0, next=STREAM.
//  STREAM: in_ready=0. data_out[i]=buf[i][col_cnt], enable_out=!stall, registered
//   (outputs valid the cycle after entry). col_cnt advances only when !stall.
//   After column MATRIX_SIZE-1 is presented with !stall: next=DRAIN, or DONE if DRAIN_CYCLES=0.
//   Latency: last row accepted at cycle t -> column 0 on data_out/enable_out at t+1.
//  DRAIN: data_out=0, enable_out=!stall, drain_cnt advances on !stall.
//   After DRAIN_CYCLES enabled cycles: next=DONE.
//  DONE: done=1, enable_out=0, data_out=0, in_ready=0 for exactly one cycle; next=LOAD.
//  stall: holds data_out and counters; enable_out=0 while stall=1. No effect in LOAD/DONE.
//  flush: highest sync priority. From any state: next=LOAD, counters cleared, enable_out=0
//   next cycle, no done pulse. A row offered with flush=1 is not accepted (in_ready=0).
//  Counter widths: $clog2 clamped to >=1 bit, so MATRIX_SIZE=1 and DRAIN_CYCLES<=1 work.
//   Wrap of row_cnt/col_cnt at MATRIX_SIZE-1 is explicit compare, not power-of-2 overflow.
//  Elements pass through unmodified; no arithmetic on data.
// STRUCTURE
//  systolic_pkg: typedef enum logic [1:0] {FEED_LOAD, FEED_STREAM, FEED_DRAIN, FEED_DONE}
//   feeder_state_t; function cnt_w(int n) returning max(1,$clog2(n)).
//  Sub-module feeder_matrix_buffer: MATRIX_SIZE x MATRIX_SIZE register array.
//   Row write port (wr_en, wr_row, row_in) and column read port (rd_col -> column vector).
//  input_feeder top holds the FSM, counters and output registers, and instantiates the buffer.
// TESTING
//  T1 N=2: rows {1,2},{3,4} back-to-back -> enabled vectors {1,3},{2,4}, then 6 zero vectors,
//     done pulse, in_ready=1 next cycle.
//  T2 N=2: in_valid toggled 1,0,1 -> only 2 rows accepted. in_ready=0 from STREAM entry
//     until after DONE.
//  T3 N=3: stall high 2 cycles mid-STREAM -> enable_out=0 and data_out held during stall.
//     Column order still 0,1,2, 3 enabled columns total.
//  T4: flush during DRAIN -> no done pulse, state LOAD next cycle. New matrix streams correctly.
//  T5: async reset asserted mid-STREAM (not on clk edge) -> outputs zero immediately,
//     in_ready=1. The old matrix never resumes.
//  T6 N=1, DRAIN_CYCLES=0: row {7} -> one enabled vector {7}, then done pulse.

Source files
------------

// File: rtl/input_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_feeder_pkg
//  Purpose  : Shared types and helpers for the input_feeder block: the
//             feeder FSM state encoding and a counter-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package input_feeder_pkg;

    typedef enum logic [1:0] {
        FEED_LOAD   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_DONE   = 2'd3
    } feeder_state_t;

    // Width needed to count 0..n-1, never narrower than one bit so that
    // degenerate sizes (n = 0, 1, 2) still yield a legal vector.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : input_feeder_pkg
`default_nettype wire

// File: rtl/input_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_feeder_if
//  Purpose  : Row-load handshake bundle feeding input_feeder.
//  Signals  : in_valid  - producer has a matrix row on row_in
//             in_ready  - feeder accepts row_in this cycle
//             row_in[k] - element k of the offered row
//  Modports : master (row producer), slave (input_feeder)
//  Revision : 1.0 - initial release
// ============================================================================
interface input_feeder_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] row_in [MATRIX_SIZE];

    modport master (output in_valid, output row_in, input in_ready);
    modport slave  (input in_valid, input row_in, output in_ready);
endinterface : input_feeder_if
`default_nettype wire

// File: rtl/input_feeder_matrix_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : input_feeder_matrix_buffer
//  Purpose  : MATRIX_SIZE x MATRIX_SIZE operand store. Written one row at a
//             time, read one column at a time (combinational read).
//  Ports    : clk     - write clock
//             wr_en   - write row_in into row wr_row
//             wr_row  - destination row index
//             row_in  - row data, row_in[k] -> mem[wr_row][k]
//             rd_col  - column index to read
//             col_out - col_out[i] = mem[i][rd_col]
//  Revision : 1.0 - initial release
// ============================================================================
module input_feeder_matrix_buffer
    import input_feeder_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int IDX_W       = cnt_w(MATRIX_SIZE)
) (
    input  wire logic                 clk,
    input  wire logic                 wr_en,
    input  wire logic [IDX_W-1:0]     wr_row,
    input  wire logic [DATA_SIZE-1:0] row_in  [MATRIX_SIZE],
    input  wire logic [IDX_W-1:0]     rd_col,
    output      logic [DATA_SIZE-1:0] col_out [MATRIX_SIZE]
);

    // Contents are don't-care until written, so the array carries no reset.
    logic [DATA_SIZE-1:0] r_mem [MATRIX_SIZE][MATRIX_SIZE];

    // Index decode by explicit compare keeps every size (including 1) free
    // of out-of-range variable selects.
    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
        always_ff @(posedge clk) begin
            if (wr_en && (wr_row == IDX_W'(r))) begin
                for (int k = 0; k < MATRIX_SIZE; k++) begin
                    r_mem[r][k] <= row_in[k];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            col_out[i] = '0;
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                if (rd_col == IDX_W'(c)) begin
                    col_out[i] = r_mem[i][c];
                end
            end
        end
    end

endmodule : input_feeder_matrix_buffer
`default_nettype wire

// File: rtl/input_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : input_feeder
//  Purpose  : Loads one square operand matrix row-by-row, streams it out
//             column-by-column with an enable strobe, then drains zero
//             vectors so downstream skewer/array pipelines flush.
//  Ports    : clk        - clock
//             reset      - asynchronous active-high reset
//             flush      - synchronous abort back to LOAD (highest priority)
//             in_if      - row-load handshake (slave side)
//             stall      - downstream hold; freezes STREAM/DRAIN progress
//             data_out   - column vector, data_out[i] = A[i][col]
//             enable_out - data_out is a vector to be consumed
//             busy       - STREAM or DRAIN in progress
//             done       - one-cycle pulse after the last drain cycle
//  Revision : 1.0 - initial release
// ============================================================================
module input_feeder
    import input_feeder_pkg::*;
#(
    parameter int MATRIX_SIZE  = 2,
    parameter int DATA_SIZE    = 32,
    parameter int DRAIN_CYCLES = 3 * MATRIX_SIZE
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 flush,
    input_feeder_if.slave             in_if,
    input  wire logic                 stall,
    output      logic [DATA_SIZE-1:0] data_out [MATRIX_SIZE],
    output      logic                 enable_out,
    output      logic                 busy,
    output      logic                 done
);

    localparam int c_cnt_w   = cnt_w(MATRIX_SIZE);
    localparam int c_drain_w = cnt_w(DRAIN_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_idx_last   = c_cnt_w'(MATRIX_SIZE - 1);
    localparam logic [c_drain_w-1:0] c_drain_last =
        c_drain_w'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

    feeder_state_t        r_state,     w_state_nxt;
    logic [c_cnt_w-1:0]   r_row_cnt,   w_row_cnt_nxt;
    logic [c_cnt_w-1:0]   r_col_cnt,   w_col_cnt_nxt;
    logic [c_drain_w-1:0] r_drain_cnt, w_drain_cnt_nxt;

    logic                 w_in_ready;
    logic                 w_wr_en;
    logic [DATA_SIZE-1:0] w_col_data [MATRIX_SIZE];

    input_feeder_matrix_buffer #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .IDX_W       (c_cnt_w)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_row  (r_row_cnt),
        .row_in  (in_if.row_in),
        .rd_col  (r_col_cnt),
        .col_out (w_col_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FEED_LOAD;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_col_cnt   <= w_col_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // A row offered together with flush is refused, so a flushed cycle can
    // never leave a stray row in the buffer.
    assign w_in_ready     = (r_state == FEED_LOAD) && !flush;
    assign w_wr_en        = w_in_ready && in_if.in_valid;
    assign in_if.in_ready = w_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_row_cnt_nxt   = r_row_cnt;
        w_col_cnt_nxt   = r_col_cnt;
        w_drain_cnt_nxt = r_drain_cnt;

        if (flush) begin
            w_state_nxt     = FEED_LOAD;
            w_row_cnt_nxt   = '0;
            w_col_cnt_nxt   = '0;
            w_drain_cnt_nxt = '0;
        end else begin
            case (r_state)
                FEED_LOAD: begin
                    if (w_wr_en) begin
                        if (r_row_cnt == c_idx_last) begin
                            w_row_cnt_nxt = '0;
                            w_state_nxt   = FEED_STREAM;
                        end else begin
                            w_row_cnt_nxt = r_row_cnt + 1'b1;
                        end
                    end
                end
                FEED_STREAM: begin
                    if (!stall) begin
                        if (r_col_cnt == c_idx_last) begin
                            w_col_cnt_nxt = '0;
                            w_state_nxt   = (DRAIN_CYCLES == 0) ? FEED_DONE : FEED_DRAIN;
                        end else begin
                            w_col_cnt_nxt = r_col_cnt + 1'b1;
                        end
                    end
                end
                FEED_DRAIN: begin
                    if (!stall) begin
                        if (r_drain_cnt == c_drain_last) begin
                            w_drain_cnt_nxt = '0;
                            w_state_nxt     = FEED_DONE;
                        end else begin
                            w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                        end
                    end
                end
                FEED_DONE: begin
                    w_state_nxt = FEED_LOAD;
                end
                default: begin
                    w_state_nxt = FEED_LOAD;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state and the buffer, so the
    // first column appears the cycle after the last row is accepted and an
    // asynchronous reset zeroes them immediately.
    assign busy       = (r_state == FEED_STREAM) || (r_state == FEED_DRAIN);
    assign enable_out = busy && !stall;
    assign done       = (r_state == FEED_DONE);

    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            data_out[i] = (r_state == FEED_STREAM) ? w_col_data[i] : '0;
        end
    end

endmodule : input_feeder
`default_nettype wire

// File: tb/tb_input_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_feeder
//  Purpose  : Scoreboard bench for input_feeder. Three instances cover
//             N=2 (load/stream/drain, valid gaps, flush, async reset),
//             N=3 (stall) and N=1 with no drain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: N=2, DRAIN=6 ----------------
    logic        rst_a, flush_a, stall_a, en_a, busy_a, done_a;
    logic [31:0] dout_a [2];
    input_feeder_if #(.MATRIX_SIZE(2), .DATA_SIZE(32)) if_a ();
    input_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut_a (
        .clk(clk), .reset(rst_a), .flush(flush_a), .in_if(if_a), .stall(stall_a),
        .data_out(dout_a), .enable_out(en_a), .busy(busy_a), .done(done_a));

    // ---------------- instance B: N=3, DRAIN=9 ----------------
    logic        rst_b, flush_b, stall_b, en_b, busy_b, done_b;
    logic [31:0] dout_b [3];
    input_feeder_if #(.MATRIX_SIZE(3), .DATA_SIZE(32)) if_b ();
    input_feeder #(.MATRIX_SIZE(3), .DATA_SIZE(32)) dut_b (
        .clk(clk), .reset(rst_b), .flush(flush_b), .in_if(if_b), .stall(stall_b),
        .data_out(dout_b), .enable_out(en_b), .busy(busy_b), .done(done_b));

    // ---------------- instance C: N=1, DRAIN=0 ----------------
    logic        rst_c, flush_c, stall_c, en_c, busy_c, done_c;
    logic [31:0] dout_c [1];
    input_feeder_if #(.MATRIX_SIZE(1), .DATA_SIZE(32)) if_c ();
    input_feeder #(.MATRIX_SIZE(1), .DATA_SIZE(32), .DRAIN_CYCLES(0)) dut_c (
        .clk(clk), .reset(rst_c), .flush(flush_c), .in_if(if_c), .stall(stall_c),
        .data_out(dout_c), .enable_out(en_c), .busy(busy_c), .done(done_c));

    // Expected enabled vectors, packed with data_out[0] in the low word.
    logic [95:0] q_a[$];
    logic [95:0] q_b[$];
    logic [95:0] q_c[$];
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [95:0] got, inout logic [95:0] q[$]);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got %0h expected no enabled vector", name, got);
        end else begin
            check(name, got, q.pop_front());
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_a) begin
            if (done_a) done_cnt_a++;
            if (en_a) pop_cmp("a_vector", {64'b0, dout_a[1], dout_a[0]}, q_a);
        end
        if (!rst_b) begin
            if (done_b) done_cnt_b++;
            if (en_b) pop_cmp("b_vector", {dout_b[2], dout_b[1], dout_b[0]}, q_b);
        end
        if (!rst_c) begin
            if (done_c) done_cnt_c++;
            if (en_c) pop_cmp("c_vector", {64'b0, dout_c[0]}, q_c);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_a(input logic v, input logic [31:0] r0, input logic [31:0] r1);
        if_a.in_valid  = v;
        if_a.row_in[0] = r0;
        if_a.row_in[1] = r1;
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        if_b.in_valid  = 1'b1;
        if_b.row_in[0] = r0;
        if_b.row_in[1] = r1;
        if_b.row_in[2] = r2;
        @(posedge clk); #1;
    endtask

    task automatic push_zeros_a(input int n);
        for (int i = 0; i < n; i++) q_a.push_back('0);
    endtask

    // {done, busy, enable_out, in_ready} of the selected instance
    function automatic logic [3:0] status(input int which);
        case (which)
            0:       return {done_a, busy_a, en_a, if_a.in_ready};
            1:       return {done_b, busy_b, en_b, if_b.in_ready};
            default: return {done_c, busy_c, en_c, if_c.in_ready};
        endcase
    endfunction

    // Waits for the done pulse; until then the feeder must be busy and
    // refusing rows. Checks the pulse is single-cycle and in_ready returns.
    task automatic wait_done(input int which, input int budget);
        logic [3:0] s;
        bit seen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            s = status(which);
            if (s[3]) begin
                seen = 1;
                check($sformatf("i%0d_done_cycle_busy_en_ready", which), {93'b0, s[2:0]}, 96'b0);
                break;
            end
            check($sformatf("i%0d_busy_not_ready", which), {94'b0, s[2], s[0]}, 96'b10);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL i%0d_done_timeout: got no done pulse expected one within %0d cycles", which, budget);
        end
        @(negedge clk);
        s = status(which);
        check($sformatf("i%0d_after_done_done_ready", which), {94'b0, s[3], s[0]}, 96'b01);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        flush_a = 0; flush_b = 0; flush_c = 0;
        stall_a = 0; stall_b = 0; stall_c = 0;
        if_a.in_valid = 0; if_b.in_valid = 0; if_c.in_valid = 0;
        if_a.row_in[0] = '0; if_a.row_in[1] = '0;
        if_b.row_in[0] = '0; if_b.row_in[1] = '0; if_b.row_in[2] = '0;
        if_c.row_in[0] = '0;

        // Reset state
        @(negedge clk);
        check("a_reset_status", {92'b0, status(0)}, 96'b0001);
        check("a_reset_data", {64'b0, dout_a[1], dout_a[0]}, 96'b0);
        check("b_reset_status", {92'b0, status(1)}, 96'b0001);
        check("c_reset_status", {92'b0, status(2)}, 96'b0001);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0; rst_c = 0;

        // T1: back-to-back rows {1,2},{3,4}
        q_a.push_back({64'b0, 32'd3, 32'd1});
        q_a.push_back({64'b0, 32'd4, 32'd2});
        push_zeros_a(6);
        send_a(1, 32'd1, 32'd2);
        send_a(1, 32'd3, 32'd4);
        if_a.in_valid = 0;
        wait_done(0, 20);

        // T2: valid gap between rows {20,21},{22,23}
        q_a.push_back({64'b0, 32'd22, 32'd20});
        q_a.push_back({64'b0, 32'd23, 32'd21});
        push_zeros_a(6);
        send_a(1, 32'd20, 32'd21);
        send_a(0, 32'hdead, 32'hbeef);
        send_a(1, 32'd22, 32'd23);
        if_a.in_valid = 0;
        wait_done(0, 20);

        // T4: flush during DRAIN, then a flushed row offer, then a new matrix
        q_a.push_back({64'b0, 32'd7, 32'd5});
        q_a.push_back({64'b0, 32'd8, 32'd6});
        push_zeros_a(2);
        send_a(1, 32'd5, 32'd6);
        send_a(1, 32'd7, 32'd8);
        if_a.in_valid = 0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        flush_a = 1;
        @(posedge clk); #1;
        if_a.in_valid  = 1;
        if_a.row_in[0] = 32'd99;
        if_a.row_in[1] = 32'd99;
        @(negedge clk);
        check("a_flush_to_load_status", {92'b0, status(0)}, 96'b0000);
        @(posedge clk); #1;
        flush_a = 0;
        q_a.push_back({64'b0, 32'd11, 32'd9});
        q_a.push_back({64'b0, 32'd12, 32'd10});
        push_zeros_a(6);
        send_a(1, 32'd9, 32'd10);
        send_a(1, 32'd11, 32'd12);
        if_a.in_valid = 0;
        wait_done(0, 20);

        // T5: async reset between edges mid-STREAM
        q_a.push_back({64'b0, 32'd15, 32'd13});
        send_a(1, 32'd13, 32'd14);
        send_a(1, 32'd15, 32'd16);
        if_a.in_valid = 0;
        @(negedge clk);
        #2 rst_a = 1;
        #1;
        check("a_async_reset_status", {92'b0, status(0)}, 96'b0001);
        check("a_async_reset_data", {64'b0, dout_a[1], dout_a[0]}, 96'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_a = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("a_post_reset_idle", {92'b0, status(0)}, 96'b0001);
        end

        // T3: N=3 with a two-cycle stall while column 1 is presented
        q_b.push_back({32'd7, 32'd4, 32'd1});
        q_b.push_back({32'd8, 32'd5, 32'd2});
        q_b.push_back({32'd9, 32'd6, 32'd3});
        for (int i = 0; i < 9; i++) q_b.push_back('0);
        send_b(32'd1, 32'd2, 32'd3);
        send_b(32'd4, 32'd5, 32'd6);
        send_b(32'd7, 32'd8, 32'd9);
        if_b.in_valid = 0;
        @(posedge clk); #1;
        stall_b = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("b_stall_enable", {95'b0, en_b}, 96'b0);
            check("b_stall_data_held", {dout_b[2], dout_b[1], dout_b[0]}, {32'd8, 32'd5, 32'd2});
            @(posedge clk); #1;
        end
        stall_b = 0;
        wait_done(1, 30);

        // T6: N=1, no drain
        q_c.push_back({64'b0, 32'd7});
        if_c.in_valid  = 1;
        if_c.row_in[0] = 32'd7;
        @(posedge clk); #1;
        if_c.in_valid = 0;
        wait_done(2, 10);

        // Final bookkeeping
        repeat (3) @(negedge clk);
        check("a_done_count", 96'(done_cnt_a), 96'd3);
        check("b_done_count", 96'(done_cnt_b), 96'd1);
        check("c_done_count", 96'(done_cnt_c), 96'd1);
        check("a_queue_left", 96'(q_a.size()), 96'd0);
        check("b_queue_left", 96'(q_b.size()), 96'd0);
        check("c_queue_left", 96'(q_c.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_input_feeder
`default_nettype wire
